// File: rtl/psum_ofifo.sv
// Column-skew-tolerant partial-sum output FIFO: independent per-column writes, aligned row reads.
// Optional feature: define PSUM_OFIFO_RELU_EN to clamp negative output lanes to zero.
module psum_ofifo #(
  parameter int COL   = 8,
  parameter int BW    = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COL-1:0]    wr,
  input  logic [COL*BW-1:0] in,
  input  logic              rd,
  output logic [COL*BW-1:0] out,
  output logic              o_out_valid,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic [AW:0]       o_level,
  output logic [1:0]        o_err
);

  localparam logic [AW:0]   L_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] L_PTR_ONE = AW'(1);

  logic [BW-1:0]     r_mem [COL][DEPTH];
  logic [AW-1:0]     r_wptr [COL];
  logic [AW:0]       r_cnt [COL];
  logic [AW-1:0]     r_rptr;
  logic [COL*BW-1:0] r_out;
  logic              r_out_valid;
  logic [1:0]        r_err;

  logic [COL-1:0]    w_empty;
  logic [COL-1:0]    w_full;
  logic [COL-1:0]    w_wr_acc;
  logic              w_rd_acc;
  logic [AW:0]       w_min;
  logic [BW-1:0]     w_lane;
  logic [COL*BW-1:0] w_row;

  // Status is decoded purely from registered counts; wr/rd only steer next state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_empty  = '0;
    w_full   = '0;
    w_wr_acc = '0;
    w_min    = L_FULL;
    w_lane   = '0;
    w_row    = '0;
    for (int i = 0; i < COL; i++) begin
      w_empty[i]  = (r_cnt[i] == '0);
      w_full[i]   = (r_cnt[i] == L_FULL);
      w_wr_acc[i] = wr[i] && !w_full[i];
      if (r_cnt[i] < w_min) w_min = r_cnt[i];
      w_lane = r_mem[i][r_rptr];
`ifdef PSUM_OFIFO_RELU_EN
      w_row[BW*i +: BW] = w_lane[BW-1] ? '0 : w_lane;
`else
      w_row[BW*i +: BW] = w_lane;
`endif
    end
  end

  assign o_valid  = ~|w_empty;
  assign o_full   = |w_full;
  assign o_ready  = &w_empty;
  assign o_level  = w_min;
  assign w_rd_acc = rd && o_valid;

  // NOTE: storage has no reset; counts define which entries are live, so the array can map to RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < COL; i++) begin
      if (!reset && w_wr_acc[i]) r_mem[i][r_wptr[i]] <= in[BW*i +: BW];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from start-of-cycle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COL; i++) begin
        r_wptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_rptr      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_err       <= '0;
    end else begin
      for (int i = 0; i < COL; i++) begin
        if (w_wr_acc[i]) r_wptr[i] <= r_wptr[i] + L_PTR_ONE;
        unique case ({w_wr_acc[i], w_rd_acc})
          2'b10:   r_cnt[i] <= r_cnt[i] + L_CNT_ONE;
          2'b01:   r_cnt[i] <= r_cnt[i] - L_CNT_ONE;
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + L_PTR_ONE;
        r_out  <= w_row;
      end
      r_out_valid <= w_rd_acc;
      r_err       <= r_err | {rd && !o_valid, |(wr & w_full)};
    end
  end

  assign out         = r_out;
  assign o_out_valid = r_out_valid;
  assign o_err       = r_err;

endmodule

// File: tb/tb_psum_ofifo.sv
// Scoreboard bench for psum_ofifo: stimulus queues expected rows, a negedge monitor pops and compares.
module tb_psum_ofifo;
  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int W     = COL * BW;

  logic          clk = 1'b0;
  logic          reset;
  logic [COL-1:0] wr;
  logic [W-1:0]  in;
  logic          rd;
  logic [W-1:0]  out;
  logic          o_out_valid, o_valid, o_full, o_ready;
  logic [AW:0]   o_level;
  logic [1:0]    o_err;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] row_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_out = '0;

  always #5 clk = ~clk;

  psum_ofifo #(.COL(COL), .BW(BW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr(wr), .in(in), .rd(rd), .out(out),
    .o_out_valid(o_out_valid), .o_valid(o_valid), .o_full(o_full),
    .o_ready(o_ready), .o_level(o_level), .o_err(o_err)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] relu(input logic [W-1:0] r);
    logic [W-1:0] o;
    o = r;
`ifdef PSUM_OFIFO_RELU_EN
    for (int i = 0; i < COL; i++)
      if (r[BW*i + BW-1]) o[BW*i +: BW] = '0;
`endif
    return o;
  endfunction

  function automatic logic [W-1:0] mk_row(input int base, input int k);
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[BW*i +: BW] = BW'(base + k*COL + i);
    return r;
  endfunction

  // Monitor: every output pulse must match the oldest expected row.
  always @(negedge clk) begin
    if (o_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", {{(W-1){1'b0}}, o_out_valid}, '0);
      end else begin
        check("row_data", out, relu(exp_q.pop_front()));
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One cycle of all-column write and/or read, with the reference row queue updated alongside.
  task automatic cycle(input logic do_wr, input logic [W-1:0] row, input logic do_rd);
    int sz;
    logic [W-1:0] r;
    sz = row_q.size();
    wr = do_wr ? '1 : '0;
    in = row;
    rd = do_rd;
    if (do_rd && sz > 0) begin
      r = row_q.pop_front();
      exp_q.push_back(r);
      last_out = relu(r);
    end
    if (do_wr && sz < DEPTH) row_q.push_back(row);
    step();
    wr = '0;
    rd = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    reset = 1'b0;
    row_q.delete();
    last_out = '0;
  endtask

  initial begin
    logic [W-1:0] skew_row;
    logic [W-1:0] relu_row;
    reset = 1'b1; wr = '0; in = '0; rd = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_out", out, '0);
    check("rst_out_valid", W'(o_out_valid), W'(0));
    check("rst_valid", W'(o_valid), W'(0));
    check("rst_full", W'(o_full), W'(0));
    check("rst_ready", W'(o_ready), W'(1));
    check("rst_level", W'(o_level), W'(0));
    check("rst_err", W'(o_err), W'(0));

    // Skewed fill: column i written at cycle i.
    for (int i = 0; i < COL; i++) begin
      wr = COL'(1) << i;
      for (int j = 0; j < COL; j++) in[BW*j +: BW] = BW'(16'h0100 + i);
      skew_row[BW*i +: BW] = BW'(16'h0100 + i);
      step();
      wr = '0;
      check("skew_valid", W'(o_valid), (i == COL-1) ? W'(1) : W'(0));
    end
    check("skew_level", W'(o_level), W'(1));
    row_q.push_back(skew_row);
    cycle(1'b0, '0, 1'b1);
    check("skew_out_valid", W'(o_out_valid), W'(1));
    check("skew_ready", W'(o_ready), W'(1));
    step();
    check("skew_out_valid_pulse", W'(o_out_valid), W'(0));

    // Fill to full, then overflow on column 3.
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, mk_row(16'h2000, k), 1'b0);
    check("full_flag", W'(o_full), W'(1));
    check("full_level", W'(o_level), W'(DEPTH));
    check("full_err_clean", W'(o_err), W'(0));
    wr = 8'h08; in = '1;
    step();
    wr = '0;
    check("ovf_err", W'(o_err), W'(2'b01));
    check("ovf_level", W'(o_level), W'(DEPTH));
    for (int k = 0; k < DEPTH; k++) cycle(1'b0, '0, 1'b1);
    step();
    check("drain_ready", W'(o_ready), W'(1));
    check("drain_valid", W'(o_valid), W'(0));

    // Underflow: column 5 empty, others hold one entry.
    wr = 8'hDF; in = mk_row(16'h4000, 0);
    step();
    wr = '0;
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("udf_out_valid", W'(o_out_valid), W'(0));
    check("udf_out_hold", out, last_out);
    check("udf_err", W'(o_err), W'(2'b11));
    check("udf_level", W'(o_level), W'(0));
    do_reset();

    // Reset mid-stream during a read.
    cycle(1'b0, '0, 1'b1);
    check("empty_rd_err", W'(o_err), W'(2'b10));
    for (int k = 0; k < 10; k++) cycle(1'b1, mk_row(16'h5000, k), 1'b0);
    check("ms_level", W'(o_level), W'(10));
    reset = 1'b1; rd = 1'b1;
    step();
    reset = 1'b0; rd = 1'b0;
    row_q.delete();
    check("ms_ready", W'(o_ready), W'(1));
    check("ms_valid", W'(o_valid), W'(0));
    check("ms_level0", W'(o_level), W'(0));
    check("ms_err", W'(o_err), W'(0));
    check("ms_out", out, '0);
    check("ms_out_valid", W'(o_out_valid), W'(0));
    cycle(1'b1, mk_row(16'h6000, 0), 1'b0);
    cycle(1'b0, '0, 1'b1);

    // Wrap: 63 rows resident, then 200 cycles of simultaneous write and read.
    for (int k = 0; k < DEPTH-1; k++) cycle(1'b1, mk_row(16'h3000, k), 1'b0);
    for (int k = DEPTH-1; k < DEPTH-1+200; k++) begin
      cycle(1'b1, mk_row(16'h3000, k), 1'b1);
      check("wrap_level", W'(o_level), W'(DEPTH-1));
    end
    for (int k = 0; k < DEPTH-1; k++) cycle(1'b0, '0, 1'b1);
    step();
    check("wrap_ready", W'(o_ready), W'(1));

    // Signed lanes through the output register.
    relu_row = mk_row(16'h0010, 0);
    relu_row[BW*2 +: BW] = 16'hFF38;
    relu_row[BW*4 +: BW] = 16'h00C8;
    relu_row[BW*7 +: BW] = 16'h8000;
    cycle(1'b1, relu_row, 1'b0);
    cycle(1'b0, '0, 1'b1);
`ifdef PSUM_OFIFO_RELU_EN
    check("relu_lane2", W'(out[BW*2 +: BW]), W'(16'h0000));
`else
    check("relu_lane2", W'(out[BW*2 +: BW]), W'(16'hFF38));
`endif
    check("relu_lane4", W'(out[BW*4 +: BW]), W'(16'h00C8));

    step(); step(); step();
    check("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/psum_ofifo.md
# psum_ofifo

Parametrised output FIFO that collects partial sums from the COL columns of the MAC array. Each column writes independently, so skewed column outputs are allowed. Rows are read out as full aligned rows once every column holds data. It sits between the array's psum outputs and the SRAM write-back path, with occupancy reporting, sticky error flags and an optional ReLU on the read side.

## Interface
- COL, 8, number of columns (lanes)
- BW, 16, bits per lane
- DEPTH, 64, entries per column; power of two, ≥ 2
- AW, $clog2(DEPTH), pointer width (derived; do not override)

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- wr  in  COL  per-column write strobe
- in  in  COL*BW  lane i = in[BW*(i+1)-1:BW*i]
- rd  in  1  read request for one full row
- out  out  COL*BW  registered row output
- o_out_valid  out  1  pulses with each new `out`
- o_valid  out  1  all columns non-empty (row readable)
- o_full  out  1  any column full
- o_ready  out  1  all columns empty
- o_level  out  AW+1  minimum occupancy across columns (readable rows)
- o_err  out  2  sticky flags: [0] overflow, [1] underflow

## Operation
- Each column is a circular buffer of DEPTH×BW with its own write pointer and count (AW+1 bits). One read pointer is shared by all columns.
- **Write, column i:** accepted iff wr[i] && count[i] < DEPTH, using the start-of-cycle count.
  - Stores lane i at wptr[i].
  - wptr[i] wraps modulo DEPTH.
- **Write to a full column:** dropped; memory and pointer are unchanged; sets o_err[0].
- **Read:** accepted iff rd && o_valid.
  - Captures all lanes at rptr into `out`.
  - rptr increments modulo DEPTH.
  - Every count decrements.
- **rd while !o_valid:** ignored; `out` holds its value; sets o_err[1].
- **Simultaneous accepted write and read on one column:** count is unchanged and both pointers advance. A full column with a same-cycle read still rejects the write, because acceptance uses the start-of-cycle count.
- **Status outputs:**
  - o_valid = AND over i of (count[i] ≠ 0).
  - o_full = OR over i of (count[i] == DEPTH).
  - o_ready = AND over i of (count[i] == 0).
  - o_level = min over i of count[i].
- All status outputs are decoded from registered counts only. There is no combinational path from wr or rd to any output.
- o_err bits are sticky until reset.
- **Reset values:** out=0, o_out_valid=0, o_valid=0, o_full=0, o_ready=1, o_level=0, o_err=0.
- **Reset mid-operation:** pointers and counts are cleared in the same edge; any in-flight write or read in that cycle is discarded. Memory contents are not reset.

## Timing
- Write-to-visible latency: 1 cycle. Data written at edge N is counted at N, so o_valid can assert after edge N and a row is readable in the cycle after the last column's write.
- Read latency: 1 cycle. A read accepted at edge N drives `out` and o_out_valid=1 after edge N.
- o_out_valid is high for exactly one cycle per accepted read.
- Back-to-back reads sustain 1 row/cycle while o_valid stays high.
- Full-throughput steady state is supported: 1 write per column and 1 read per cycle.

## Configuration
- `PSUM_OFIFO_RELU_EN` defined: each lane of `out` is treated as signed BW-bit. A negative lane (MSB=1) is output as 0; other lanes pass unchanged. Applied at the output register; latency is unchanged.
- `PSUM_OFIFO_RELU_EN` undefined: lanes pass through unmodified as raw bits.

## Test plan
- **Skewed fill:** with COL=8, write column i at cycle i (lane value 0x0100+i) → o_valid stays 0 until the cycle after column 7's write. Then rd → `out` lanes = 0x0100..0x0107 one cycle later, o_out_valid pulses once, o_ready=1.
- **Full/overflow:** write all columns 64 times → o_full=1, o_level=64. A 65th write on column 3 is dropped and sets o_err[0]=1. 64 reads return the data in order with no corruption.
- **Underflow:** rd with column 5 empty and the others holding 1 entry → `out` unchanged, o_out_valid=0, o_err[1]=1, o_level=0.
- **Wrap and simultaneous R/W:** sustain 200 cycles of write-all plus read with 1 entry of headroom → counts constant, pointers wrap 3×, output order matches a reference queue.
- **Reset mid-stream:** 10 rows written, reset asserted for 1 cycle during a rd → o_ready=1, o_valid=0, o_level=0, o_err=0, out=0. The next write+read returns only new data.
- **ReLU:** lane 2 = 0xFF38 (−200), lane 4 = 0x00C8 (200) → with the macro, lane 2 = 0x0000 and lane 4 = 0x00C8; without it, both pass raw.
